lfsr4_checker: RTL and testbench

- Receive-side companion to the 4-bit LFSR pattern generator: consumes the 4-bit LFSR word stream and self-synchronises to it.
- Once synchronised, checks every word against a locally predicted sequence and counts errors.
- Declares loss of lock after repeated consecutive mismatches.
- Sits beside the generator inside the Tiny Tapeout top; the top wrapper maps inputs and status onto pins.

---
 rtl/lfsr4_pkg.sv | 24 ++
 rtl/lfsr4_predictor.sv | 37 +++
 rtl/lfsr4_checker.sv | 147 ++++++++++++++
 tb/tb_lfsr4_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr4_pkg.sv
// Shared definitions for the 4-bit LFSR generator/checker pair.
// Holds the checker state encoding, the polynomial select constants and the
// single next-state function used by both ends of the link.
package lfsr4_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic POLY_A = 1'b0;  // fb = s[3] ^ s[2]
  localparam logic POLY_B = 1'b1;  // fb = s[3] ^ s[0]

  // Both polynomials are maximal length (period 15); the all-zero word is
  // the lock-up state and never reached from a non-zero seed.
  function automatic logic [3:0] lfsr4_next(input logic [3:0] s,
                                            input logic       poly_sel);
    logic fb;
    fb = (poly_sel == POLY_B) ? (s[3] ^ s[0]) : (s[3] ^ s[2]);
    return {s[2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr4_predictor.sv
// Local copy of the expected LFSR sequence.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (pred -> 0)
//   load        pred <= next(din)   (seed from the received word)
//   advance     pred <= next(pred)  (flywheel step)
//   poly_sel    polynomial select for both load and advance
//   din         received word
//   pred        current predicted word
//   match       din == pred
module lfsr4_predictor
  import lfsr4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  input  logic       poly_sel,
  input  logic [3:0] din,
  output logic [3:0] pred,
  output logic       match
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred <= '0;
    end else if (load) begin
      pred <= lfsr4_next(din, poly_sel);
    end else if (advance) begin
      pred <= lfsr4_next(pred, poly_sel);
    end
  end

  always_comb begin
    match = (din == pred);
  end

endmodule

// File: rtl/lfsr4_checker.sv
// Receive-side checker for the 4-bit LFSR pattern stream.
// Self-synchronises on a non-zero word, verifies LOCK_CNT further matches,
// then flywheels the prediction and counts mismatching words. LOSS_CNT
// consecutive mismatches while locked drop back to SEARCH.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   din          received LFSR word (sampled only when din_valid)
//   din_valid    qualifies din; low holds all state
//   poly_sel     polynomial select (see lfsr4_pkg)
//   clr_err      clears err_cnt and lost_sticky (wins over same-cycle update)
//   locked       high while in LOCKED
//   err_pulse    one-cycle pulse per mismatching valid word in LOCKED
//   err_cnt      saturating mismatch count
//   lost_sticky  set on every LOCKED -> SEARCH transition
//   state        SEARCH=0, VERIFY=1, LOCKED=2
module lfsr4_checker
  import lfsr4_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       din,
  input  logic             din_valid,
  input  logic             poly_sel,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             lost_sticky,
  output logic [1:0]       state
);

  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_TGT = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t     state_q, state_d;
  logic [3:0] match_cnt, match_cnt_d;
  logic [3:0] miss_cnt, miss_cnt_d;
  logic       load, advance, mismatch, lose;
  logic [3:0] pred;
  logic       match;

  lfsr4_predictor u_pred (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .advance  (advance),
    .poly_sel (poly_sel),
    .din      (din),
    .pred     (pred),
    .match    (match)
  );

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt;
    miss_cnt_d  = miss_cnt;
    load        = 1'b0;
    advance     = 1'b0;
    mismatch    = 1'b0;
    lose        = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (din != '0) begin
            load        = 1'b1;
            match_cnt_d = '0;
            state_d     = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            advance = 1'b1;
            if (match_cnt + 4'd1 == LOCK_TGT) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              match_cnt_d = match_cnt + 4'd1;
            end
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction steps on every valid word so a single
          // corrupted word costs exactly one error.
          advance = 1'b1;
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            mismatch = 1'b1;
            if (miss_cnt + 4'd1 == LOSS_TGT) begin
              state_d    = SEARCH;
              miss_cnt_d = '0;
              lose       = 1'b1;
            end else begin
              miss_cnt_d = miss_cnt + 4'd1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_cnt     <= '0;
      lost_sticky <= 1'b0;
    end else begin
      if (din_valid) begin
        state_q   <= state_d;
        match_cnt <= match_cnt_d;
        miss_cnt  <= miss_cnt_d;
        locked    <= (state_d == LOCKED);
        err_pulse <= mismatch;
      end else begin
        err_pulse <= 1'b0;
      end

      if (clr_err) begin
        err_cnt <= '0;
      end else if (mismatch && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_ONE;
      end

      if (clr_err) begin
        lost_sticky <= 1'b0;
      end else if (lose) begin
        lost_sticky <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_lfsr4_checker.sv
module tb_lfsr4_checker;

  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       din = '0;
  logic             din_valid = 1'b0;
  logic             poly_sel = 1'b0;
  logic             clr_err = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic             lost_sticky;
  logic [1:0]       state;

  lfsr4_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .poly_sel    (poly_sel),
    .clr_err     (clr_err),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt),
    .lost_sticky (lost_sticky),
    .state       (state)
  );

  always #5 clk = ~clk;

  // The two maximal-length sequences written out as tables; the model
  // advances by position in the table rather than by shifting bits.
  logic [3:0] seq_a [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] seq_b [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                             4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0=search, 1=verify, 2=locked
  int         m_state = 0;
  logic [3:0] m_pred  = '0;
  int         m_match = 0;
  int         m_miss  = 0;
  int         m_err   = 0;
  bit         m_lost  = 0;
  bit         m_pulse = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] follow(input logic [3:0] v, input logic p);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 15; i++) begin
      if (p == 1'b0 && seq_a[i] == v) r = seq_a[(i + 1) % 15];
      if (p == 1'b1 && seq_b[i] == v) r = seq_b[(i + 1) % 15];
    end
    return r;
  endfunction

  task automatic model_step(input logic [3:0] d, input logic v, input logic p, input logic c);
    m_pulse = 0;
    if (v) begin
      case (m_state)
        0: if (d != 0) begin
             m_pred  = follow(d, p);
             m_match = 0;
             m_state = 1;
           end
        1: if (d == m_pred) begin
             m_pred = follow(m_pred, p);
             m_match++;
             if (m_match == LOCK_CNT) begin
               m_state = 2;
               m_miss  = 0;
             end
           end else begin
             m_state = 0;
           end
        default: begin
          if (d != m_pred) begin
            m_pulse = 1;
            if (m_err < ERR_MAX) m_err++;
            m_miss++;
            if (m_miss == LOSS_CNT) begin
              m_state = 0;
              m_miss  = 0;
              m_lost  = 1;
            end
          end else begin
            m_miss = 0;
          end
          m_pred = follow(m_pred, p);
        end
      endcase
    end
    if (c) begin
      m_err  = 0;
      m_lost = 0;
    end
  endtask

  task automatic check_all();
    chk("state", int'(state), m_state);
    chk("locked", int'(locked), int'(m_state == 2));
    chk("err_pulse", int'(err_pulse), int'(m_pulse));
    chk("err_cnt", int'(err_cnt), m_err);
    chk("lost_sticky", int'(lost_sticky), int'(m_lost));
  endtask

  task automatic cyc(input logic [3:0] d, input logic v, input logic p, input logic c);
    @(negedge clk);
    rst_n = 1'b1; din = d; din_valid = v; poly_sel = p; clr_err = c;
    @(posedge clk); #1;
    model_step(d, v, p, c);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_valid = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1;
    m_state = 0; m_pred = '0; m_match = 0; m_miss = 0;
    m_err = 0; m_lost = 0; m_pulse = 0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic acquire(input logic p);
    cyc(4'h1, 1'b1, p, 1'b0);
    for (int i = 0; i < LOCK_CNT; i++) cyc(m_pred, 1'b1, p, 1'b0);
  endtask

  initial begin
    do_reset();

    // Acquire on polynomial A
    cyc(4'h1, 1, 0, 0); chk("acq_s1", int'(state), 1);
    cyc(4'h2, 1, 0, 0); chk("acq_s2", int'(state), 1);
    cyc(4'h4, 1, 0, 0); chk("acq_s3", int'(state), 1);
    cyc(4'h9, 1, 0, 0); chk("acq_locked", int'(locked), 1);

    // Single corrupted word; flywheel keeps the following word aligned
    cyc(4'h3, 1, 0, 0);
    cyc(4'h7, 1, 0, 0); chk("single_pulse", int'(err_pulse), 1);
    cyc(4'hD, 1, 0, 0); chk("single_cnt", int'(err_cnt), 1);
    chk("single_locked", int'(locked), 1);
    chk("single_no_pulse", int'(err_pulse), 0);

    // Gap of invalid cycles while locked
    for (int i = 0; i < 5; i++) cyc(4'($urandom), 0, 0, 0);
    chk("gap_locked", int'(state), 2);

    // Loss of lock
    for (int i = 0; i < LOSS_CNT; i++) cyc(m_pred ^ 4'h5, 1, 0, 0);
    chk("loss_state", int'(state), 0);
    chk("loss_sticky", int'(lost_sticky), 1);
    chk("loss_cnt", int'(err_cnt), 1 + LOSS_CNT);

    // Zero word never seeds
    cyc(4'h0, 1, 0, 0); chk("zero_search", int'(state), 0);

    // Mismatch during VERIFY
    cyc(4'h1, 1, 0, 0);
    cyc(4'h5, 1, 0, 0); chk("verify_drop", int'(state), 0);
    chk("verify_no_err", int'(err_cnt), 1 + LOSS_CNT);

    // Saturation
    for (int k = 0; k < 80; k++) begin
      acquire(1'b0);
      for (int i = 0; i < LOSS_CNT; i++) cyc(m_pred ^ 4'h5, 1, 0, 0);
    end
    chk("sat_cnt", int'(err_cnt), ERR_MAX);

    // clr_err coincident with a mismatch
    acquire(1'b0);
    cyc(m_pred ^ 4'h5, 1, 0, 1);
    chk("clr_cnt", int'(err_cnt), 0);
    chk("clr_sticky", int'(lost_sticky), 0);

    // Reset while locked, then acquire on polynomial B
    cyc(m_pred, 1, 0, 0);
    do_reset();
    cyc(4'h1, 1, 1, 0);
    cyc(4'h3, 1, 1, 0);
    cyc(4'h7, 1, 1, 0);
    cyc(4'hF, 1, 1, 0); chk("polyb_locked", int'(locked), 1);

    // Randomised traffic against the model
    begin
      logic p;
      p = 1'b1;
      for (int n = 0; n < 2000; n++) begin
        logic [3:0] d;
        logic v, c;
        if ($urandom_range(0, 299) == 0) do_reset();
        if ($urandom_range(0, 149) == 0) p = ~p;
        v = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 9) < 8 && m_state != 0) d = m_pred;
        else d = 4'($urandom);
        cyc(d, v, p, c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
